ifetch_queue: RTL and testbench

Instruction fetch queue between the program counter / instruction memory and the decode stage (Control, Registers). It owns the fetch PC and issues word reads to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered with their PCs in a small FIFO and presented to decode through a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new address, for branch/jump support.

---
 rtl/ifq_pkg.sv | 21 ++
 rtl/ifq_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } ifq_state_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] ifq_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of {pc, instr} records with flush. Pointers and count are
// reset; the storage array is not, and the head is forced to zero when empty
// so unwritten storage never reaches the outputs.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               push_entry,
  input  logic                     pop,
  output ifq_entry_t               head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A flush discards any push or pop in the same cycle; boundaries are guarded.
  assign do_push = push && !flush && (count != FULL);
  assign do_pop  = pop && !flush && (count != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues word reads to a 1-cycle
// latency instruction memory, buffers returned words with their PCs and hands
// them to decode over valid/ready. A redirect flushes and restarts fetch.
// Optional build macro IFQ_PERF_EN adds pop and stall performance counters.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic [31:0]            imem_instr_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [31:0]            instr_o,
  output logic [31:0]            pc_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]            perf_fetched_o,
  output logic [31:0]            perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  ifq_state_t  state;
  ifq_state_t  state_next;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        inflight;
  logic        squash;
  logic [CNT_W:0] occupied;
  logic        push;
  logic        pop;
  ifq_entry_t  push_entry;
  ifq_entry_t  head;

  // Queued entries plus the one outstanding response bound the request rate.
  assign occupied = {1'b0, count_o} + {{CNT_W{1'b0}}, inflight};

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and request issue.
  always_comb begin
    state_next = state;
    imem_req_o = 1'b0;
    case (state)
      IDLE:    if (start_i)  state_next = FETCH;
      FETCH:   if (!start_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    imem_req_o = (state == FETCH) && !redirect_i && (occupied < CREDIT_LIMIT);
  end

  assign imem_addr_o = fetch_pc;

  // Fetch PC, in-flight flag and squash flag; redirect takes priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= imem_req_o;
      squash   <= redirect_i && inflight;
      if (redirect_i)      fetch_pc <= ifq_align(redirect_pc_i);
      else if (imem_req_o) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // --- request stage -> response stage: remember the PC of the issued read ---
  always_ff @(posedge clk_i) begin
    if (imem_req_o) req_pc <= fetch_pc;
  end

  // --- response stage -> queue: capture the returned word unless squashed ---
  assign push       = inflight && !squash;
  assign push_entry = '{pc: req_pc, instr: imem_instr_i};
  assign pop        = valid_o && ready_i;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush      (redirect_i),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .valid      (valid_o),
    .count      (count_o)
  );

  assign instr_o = head.instr;
  assign pc_o    = head.pc;

`ifdef IFQ_PERF_EN
  // Performance counters; only reset clears them, redirect does not.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (pop && !redirect_i)    perf_fetched_o <= perf_fetched_o + 32'd1;
      if (valid_o && !ready_i)   perf_stall_o   <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: a table of per-cycle vectors for startup,
// steady state and backpressure, then hand-written redirect, start/stop,
// address wrap and asynchronous reset sequences. The memory model returns
// address + 0x100 one cycle after each request.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i = '0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  count_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          st;
    bit          rdy;
    bit          rd;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle latency.
  always @(posedge clk) begin
    if (imem_req_o) imem_instr_i <= imem_addr_o + 32'h100;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit rdy, input bit rd, input logic [31:0] rpc,
                              input bit rq, input logic [31:0] ad, input bit v,
                              input logic [31:0] pc, input int cnt);
    vec_t r;
    r.st = st; r.rdy = rdy; r.rd = rd; r.rpc = rpc;
    r.e_req = rq; r.e_addr = ad; r.e_vld = v; r.e_pc = pc; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, ".req"},   32'(imem_req_o), 32'd0);
    chk({tag, ".addr"},  imem_addr_o,     32'h0000_0000);
    chk({tag, ".valid"}, 32'(valid_o),    32'd0);
    chk({tag, ".instr"}, instr_o,         32'd0);
    chk({tag, ".pc"},    pc_o,            32'd0);
    chk({tag, ".count"}, 32'(count_o),    32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    @(posedge clk); #1;
    check_reset_values("reset");
    rst_i = 1'b1;
  endtask

  // Apply one cycle's inputs, check that cycle's outputs, advance one edge.
  task automatic cyc(input string tag, input vec_t v);
    start_i = v.st; ready_i = v.rdy; redirect_i = v.rd; redirect_pc_i = v.rpc;
    #1;
    chk({tag, ".req"}, 32'(imem_req_o), 32'(v.e_req));
    if (v.e_req) chk({tag, ".addr"}, imem_addr_o, v.e_addr);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v.e_vld));
    chk({tag, ".count"}, 32'(count_o), 32'(v.e_cnt));
    if (v.e_vld) begin
      chk({tag, ".pc"},    pc_o,    v.e_pc);
      chk({tag, ".instr"}, instr_o, v.e_pc + 32'h100);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Startup, steady streaming, then 10 cycles of backpressure and recovery.
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h00, 0, 32'h00, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h04, 0, 32'h00, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h08, 1, 32'h00, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0C, 1, 32'h04, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h10, 1, 32'h08, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h14, 1, 32'h0C, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'h18, 1, 32'h0C, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h1C, 1, 32'h0C, 3));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 32'h1C, 1, 32'h0C, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h1C, 1, 32'h0C, 4));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h1C, 1, 32'h10, 3));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h20, 1, 32'h14, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h24, 1, 32'h18, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h28, 1, 32'h1C, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 32'h2C, 1, 32'h20, 2));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) cyc($sformatf("stream[%0d]", i), tbl[i]);

    // Redirect to 0x203 with three queued and one response in flight.
    do_reset();
    cyc("redir0", mk(1, 0, 0, 0,            0, 32'h000, 0, 32'h000, 0));
    cyc("redir1", mk(1, 0, 0, 0,            1, 32'h000, 0, 32'h000, 0));
    cyc("redir2", mk(1, 0, 0, 0,            1, 32'h004, 0, 32'h000, 0));
    cyc("redir3", mk(1, 0, 0, 0,            1, 32'h008, 1, 32'h000, 1));
    cyc("redir4", mk(1, 0, 0, 0,            1, 32'h00C, 1, 32'h000, 2));
    cyc("redir5", mk(1, 0, 1, 32'h0000_0203, 0, 32'h010, 1, 32'h000, 3));
    cyc("redir6", mk(1, 0, 0, 0,            1, 32'h200, 0, 32'h000, 0));
    cyc("redir7", mk(1, 0, 0, 0,            1, 32'h204, 0, 32'h000, 0));
    cyc("redir8", mk(1, 1, 0, 0,            1, 32'h208, 1, 32'h200, 1));
    cyc("redir9", mk(1, 1, 0, 0,            1, 32'h20C, 1, 32'h204, 1));

    // start_i dropped after two requests, then restored.
    do_reset();
    cyc("stop0", mk(1, 1, 0, 0, 0, 32'h00, 0, 32'h00, 0));
    cyc("stop1", mk(1, 1, 0, 0, 1, 32'h00, 0, 32'h00, 0));
    cyc("stop2", mk(0, 1, 0, 0, 1, 32'h04, 0, 32'h00, 0));
    cyc("stop3", mk(0, 1, 0, 0, 0, 32'h08, 1, 32'h00, 1));
    cyc("stop4", mk(0, 1, 0, 0, 0, 32'h08, 1, 32'h04, 1));
    cyc("stop5", mk(0, 1, 0, 0, 0, 32'h08, 0, 32'h00, 0));
    cyc("stop6", mk(1, 1, 0, 0, 0, 32'h08, 0, 32'h00, 0));
    cyc("stop7", mk(1, 1, 0, 0, 1, 32'h08, 0, 32'h00, 0));
    cyc("stop8", mk(1, 1, 0, 0, 1, 32'h0C, 0, 32'h00, 0));
    cyc("stop9", mk(1, 1, 0, 0, 1, 32'h10, 1, 32'h08, 1));

    // Redirect while idle to the top word, then wrap to zero.
    do_reset();
    cyc("wrap0", mk(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,          0, 32'h0,          0));
    cyc("wrap1", mk(1, 1, 0, 0,             1, 32'hFFFF_FFFC,  0, 32'h0,          0));
    cyc("wrap2", mk(1, 1, 0, 0,             1, 32'h0000_0000,  0, 32'h0,          0));
    cyc("wrap3", mk(1, 1, 0, 0,             1, 32'h0000_0004,  1, 32'hFFFF_FFFC,  1));
    cyc("wrap4", mk(1, 1, 0, 0,             1, 32'h0000_0008,  1, 32'h0000_0000,  1));

    // Asynchronous reset in the middle of a cycle while valid_o is high.
    #1;
    chk("async.pre_valid", 32'(valid_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    check_reset_values("async");
    rst_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
